led_pwm_bank: RTL and testbench
===============================

LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 Parameter MAIN_FREQ, default 50000000: input clock frequency in Hz.
REQ-002 Parameter PWM_FREQ, default 1000: PWM period frequency in Hz.
REQ-003 Parameter PWM_S_CNT, default 200: samples per period (duty resolution), range 2..255.
REQ-004 Parameter CHANNELS, default 18: number of PWM channels, range 1..32.
REQ-005 CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-006 RESET  input  1  reset; synchronous and active-high.
REQ-007 wr_en  input  1  duty write strobe, one write per cycle.
REQ-008 wr_addr  input  5  channel index for the write.
REQ-009 wr_data  input  8  duty value, in samples.
REQ-010 pwm_out  output  CHANNELS  registered PWM outputs, bit i = channel i.
REQ-011 period_start  output  1  one-cycle pulse marking the start of each PWM period.

Function
REQ-012 Derived divider DIV = MAIN_FREQ / (PWM_FREQ * PWM_S_CNT), integer division; elaboration shall fail if DIV < 1.
REQ-013 Prescaler shall count 0..DIV-1 and wrap to 0; tick is the cycle where prescaler == DIV-1.
REQ-014 Sample counter shall increment on tick, count 0..PWM_S_CNT-1 and wrap to 0 after PWM_S_CNT-1.
REQ-015 Each channel shall hold a shadow duty register and an active duty register, 8 bits each.
REQ-016 On wr_en with wr_addr < CHANNELS, shadow[wr_addr] shall take wr_data on that edge.
REQ-017 wr_en with wr_addr >= CHANNELS shall be ignored with no state change.
REQ-018 On the edge where the sample counter wraps PWM_S_CNT-1 -> 0, every active duty shall load from shadow; a write on that same edge shall be included in the load (write-through).
REQ-019 period_start shall be high for exactly the one cycle following that wrap edge, never otherwise.
REQ-020 Compare value cmp_i = sample counter (Configuration may change this).
REQ-021 pwm_out[i] shall be registered as (cmp_i < active[i]), one cycle of latency from the counter state.
REQ-022 Duty 0 shall give a constantly low output; duty >= PWM_S_CNT shall give a constantly high output (saturation, no wrap).
REQ-023 Duty d in 1..PWM_S_CNT-1 shall give exactly d*DIV high cycles per period of PWM_S_CNT*DIV cycles.
REQ-024 Duty changes shall never take effect mid-period; no truncated or doubled pulses shall occur.

Reset
REQ-025 While RESET is high on an edge: prescaler, sample counter, all shadow and active duties, pwm_out and period_start shall be 0.
REQ-026 RESET shall override a simultaneous wr_en; the write shall be lost.
REQ-027 RESET asserted mid-period shall take effect on the next edge; after release, counting shall restart from 0 and the first period_start shall occur PWM_S_CNT*DIV cycles after release.

Configuration
REQ-028 Macro LED_PWM_BANK_PHASE_EN: when defined, cmp_i = (sample counter + i*(PWM_S_CNT/CHANNELS)) mod PWM_S_CNT, staggering channel edges.
REQ-029 Phase offsets shall not alter duty: REQ-022 and REQ-023 hold per channel over any window of PWM_S_CNT*DIV cycles.
REQ-030 When LED_PWM_BANK_PHASE_EN is undefined, cmp_i = sample counter for all channels, and all rising edges align.

Verification (defaults: DIV=250, period 50000 cycles)
REQ-031 Reset, then write ch0=100, ch1=0, ch17=200 -> after first period_start: ch0 high 25000 of 50000 cycles, ch1 always low, ch17 always high.
REQ-032 Write ch3=255 and ch4=201 -> both constantly high across a full period (saturation).
REQ-033 Write ch5=50 at mid-period -> ch5 unchanged until the next period_start, then 12500 high cycles per period.
REQ-034 Write ch6=80 on the exact wrap edge -> period beginning at that wrap shows 20000 high cycles.
REQ-035 Write wr_addr=20 with data 100 -> no pwm_out bit changes; period_start spacing stays 50000 cycles.
REQ-036 Assert RESET 1 cycle mid-period with wr_en high -> all outputs 0 next cycle; first period_start 50000 cycles after release; with LED_PWM_BANK_PHASE_EN, ch1 rising edge 11 samples (2750 cycles) offset from ch0.

Source files
------------

// File: rtl/led_pwm_bank.sv
// ---------------------------------------------------------------------------
// led_pwm_bank
//
// Bank of CHANNELS independent PWM generators that share one timebase.
//
// Timebase
//   A prescaler divides CLOCK_50 by DIV = MAIN_FREQ / (PWM_FREQ * PWM_S_CNT).
//   A sample counter advances once per prescaler tick, giving PWM_S_CNT
//   samples per PWM period of PWM_S_CNT * DIV clock cycles.
//
// Duty handling
//   Each channel owns a shadow duty register, which the write port updates,
//   and an active duty register, which drives the comparator. Active duties
//   are refreshed from the shadows only on the edge where the sample counter
//   wraps. A write landing on that same edge is forwarded into the new
//   active value. As a result, a duty change never truncates or doubles a
//   pulse.
//
// Output
//   pwm_out[i] is registered as (cmp_i < active[i]). Duty 0 gives a
//   constantly low output. Any duty >= PWM_S_CNT gives a constantly high
//   output, because the compare value never reaches PWM_S_CNT.
//
// Optional feature (macro LED_PWM_BANK_PHASE_EN)
//   When the macro is defined, channel i compares against
//   (sample counter + i * (PWM_S_CNT / CHANNELS)) mod PWM_S_CNT. This
//   staggers the channel edges so the LEDs do not all switch on the same
//   cycle. When the macro is undefined, every channel compares against the
//   raw sample counter, and all rising edges align.
//
// Ports
//   CLOCK_50      in   1         sole clock, rising edge
//   RESET         in   1         synchronous, active-high reset
//   wr_en         in   1         duty write strobe
//   wr_addr       in   5         channel index for the write
//                                (indices >= CHANNELS are ignored)
//   wr_data       in   8         duty value, in samples
//   pwm_out       out  CHANNELS  registered PWM outputs, bit i = channel i
//   period_start  out  1         one-cycle pulse in the first cycle of
//                                each PWM period
// ---------------------------------------------------------------------------
module led_pwm_bank #(
    parameter int MAIN_FREQ = 50000000,
    parameter int PWM_FREQ  = 1000,
    parameter int PWM_S_CNT = 200,
    parameter int CHANNELS  = 18
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic [4:0]          wr_addr,
    input  logic [7:0]          wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int DIV        = MAIN_FREQ / (PWM_FREQ * PWM_S_CNT);
    localparam int PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PHASE_STEP = PWM_S_CNT / CHANNELS;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [7:0]       SAMP_LAST = 8'(PWM_S_CNT - 1);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    generate
        if (DIV < 1) begin : g_bad_div
            $error("led_pwm_bank: MAIN_FREQ too low for PWM_FREQ * PWM_S_CNT (DIV < 1)");
        end
        if (PWM_S_CNT < 2 || PWM_S_CNT > 255) begin : g_bad_scnt
            $error("led_pwm_bank: PWM_S_CNT must be in 2..255");
        end
        if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_ch
            $error("led_pwm_bank: CHANNELS must be in 1..32");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State and combinational nets
    // -----------------------------------------------------------------------
    logic [PRE_W-1:0]    prescaler;
    logic [7:0]          sample_cnt;
    logic                tick;
    logic                wrap;
    logic                wr_hit;

    logic [7:0]          shadow     [CHANNELS];
    logic [7:0]          active     [CHANNELS];
    logic [7:0]          shadow_nxt [CHANNELS];
    logic [7:0]          cmp        [CHANNELS];
    logic [CHANNELS-1:0] pwm_nxt;

    // -----------------------------------------------------------------------
    // Timebase decode
    // -----------------------------------------------------------------------
    assign tick   = (prescaler == PRE_LAST);
    assign wrap   = tick && (sample_cnt == SAMP_LAST);
    assign wr_hit = wr_en && (int'(wr_addr) < CHANNELS);

    // -----------------------------------------------------------------------
    // Shadow update
    // shadow_nxt is the shadow bank as it will be after this edge. The
    // period-boundary load reads it, so a write on the wrap edge is carried
    // straight into the active duty.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no
        //       path can leave it unassigned and infer a latch.
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_nxt[i] = shadow[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit && (wr_addr == 5'(i))) begin
                shadow_nxt[i] = wr_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel compare value
    // -----------------------------------------------------------------------
`ifdef LED_PWM_BANK_PHASE_EN
    // The offset i*PHASE_STEP is always below PWM_S_CNT, so the sum stays
    // below 2*PWM_S_CNT. One conditional subtract therefore implements the
    // modulo.
    always_comb begin
        logic [8:0] sum;
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum = {1'b0, sample_cnt} + 9'(i * PHASE_STEP);
            if (sum >= 9'(PWM_S_CNT)) begin
                cmp[i] = 8'(sum - 9'(PWM_S_CNT));
            end else begin
                cmp[i] = sum[7:0];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cmp[i] = sample_cnt;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Comparator
    // cmp never exceeds PWM_S_CNT-1. Any duty >= PWM_S_CNT therefore
    // saturates high with no extra logic, and duty 0 is always low.
    // -----------------------------------------------------------------------
    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i] = (cmp[i] < active[i]);
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        // NOTE: clocked state uses non-blocking assignments only. Every
        //       register then samples pre-edge values, regardless of the
        //       order in which the statements are written.
        if (RESET) begin
            prescaler    <= '0;
            sample_cnt   <= '0;
            period_start <= 1'b0;
            pwm_out      <= '0;
            // NOTE: the duty banks are reset explicitly. They are small
            //       flop arrays rather than RAM, and a reset must also
            //       discard any pending write.
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end

            if (wrap) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 8'd1;
            end

            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (wrap) begin
                    active[i] <= shadow_nxt[i];
                end
            end

            period_start <= wrap;
            pwm_out      <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_bank
//
// Bench for led_pwm_bank, run with a reduced timebase of DIV = 5, which
// gives a period of 1000 cycles.
//
// The reference model tracks the elapsed cycles since reset. From that
// count it derives:
//   - the sample index, as (cycles / DIV) mod S;
//   - the period boundaries;
//   - the duty in force for each period.
//
// Checks performed:
//   - every cycle is checked against the model;
//   - each completed period checks the high-cycle count of every channel
//     against min(duty, S) * DIV;
//   - directed table rows and hand-written sequences cover the corner
//     cases.
// ---------------------------------------------------------------------------
module tb_led_pwm_bank;

    localparam int MAIN_FREQ = 1000000;
    localparam int PWM_FREQ  = 1000;
    localparam int S         = 200;
    localparam int CH        = 18;
    localparam int DIV       = MAIN_FREQ / (PWM_FREQ * S);
    localparam int P         = S * DIV;

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b1;
    logic          wr_en    = 1'b0;
    logic [4:0]    wr_addr  = '0;
    logic [7:0]    wr_data  = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    led_pwm_bank #(
        .MAIN_FREQ (MAIN_FREQ),
        .PWM_FREQ  (PWM_FREQ),
        .PWM_S_CNT (S),
        .CHANNELS  (CH)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int   c = 0;               // edges since the last reset edge
    bit   model_valid = 0;
    int   shadow_m [CH];
    int   act_m    [CH];
    int   hi_cnt   [CH];
    int   mis_cnt  [CH];
    int   last_hi  [CH];
    int   ps_mis = 0;
    int   win_len = 0;
    int   windows_done = 0;

    logic       cap_rst;
    logic       cap_we;
    logic [4:0] cap_a;
    logic [7:0] cap_d;

    function automatic int sat(input int d);
        return (d >= S) ? S : d;
    endfunction

    task automatic clear_window();
        for (int i = 0; i < CH; i++) begin
            hi_cnt[i]  = 0;
            mis_cnt[i] = 0;
        end
        ps_mis  = 0;
        win_len = 0;
    endtask

    task automatic check_mismatches();
        for (int i = 0; i < CH; i++) begin
            check($sformatf("pwm_cycle_mismatches ch%0d", i), mis_cnt[i], 0);
        end
        check("period_start_mismatches", ps_mis, 0);
    endtask

    task automatic model_step();
        bit [CH-1:0] exp_v;
        bit          exp_ps;
        int          samp;
        int          cmpv;
        bit          boundary;

        exp_v    = '0;
        exp_ps   = 0;
        boundary = 0;

        if (cap_rst) begin
            if (model_valid && win_len > 0) begin
                check_mismatches();
            end
            c = 0;
            for (int i = 0; i < CH; i++) begin
                shadow_m[i] = 0;
                act_m[i]    = 0;
            end
            clear_window();
            model_valid = 1;
        end else if (model_valid) begin
            samp = (c / DIV) % S;
            for (int i = 0; i < CH; i++) begin
`ifdef LED_PWM_BANK_PHASE_EN
                cmpv = (samp + i * (S / CH)) % S;
`else
                cmpv = samp;
`endif
                exp_v[i] = (cmpv < act_m[i]);
            end
            c++;
            if (cap_we && int'(cap_a) < CH) begin
                shadow_m[int'(cap_a)] = int'(cap_d);
            end
            exp_ps   = (c % P == 0);
            boundary = exp_ps;
            win_len++;
        end else begin
            return;
        end

        for (int i = 0; i < CH; i++) begin
            if (pwm_out[i] !== exp_v[i]) mis_cnt[i]++;
            if (pwm_out[i] === 1'b1)     hi_cnt[i]++;
        end
        if (period_start !== exp_ps) ps_mis++;

        if (boundary) begin
            for (int i = 0; i < CH; i++) begin
                check($sformatf("period_high_cycles ch%0d duty=%0d", i, act_m[i]),
                      hi_cnt[i], sat(act_m[i]) * DIV);
                last_hi[i] = hi_cnt[i];
            end
            check_mismatches();
            clear_window();
            windows_done++;
            for (int i = 0; i < CH; i++) begin
                act_m[i] = shadow_m[i];
            end
        end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            shadow_m[i] = 0;
            act_m[i]    = 0;
            last_hi[i]  = -1;
        end
        clear_window();
        forever begin
            @(posedge CLOCK_50);
            cap_rst = RESET;
            cap_we  = wr_en;
            cap_a   = wr_addr;
            cap_d   = wr_data;
            @(negedge CLOCK_50);
            model_step();
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // Inputs change 1 time unit after the falling edge, well away from the
    // active edge and after the model has updated for this cycle.
    // -----------------------------------------------------------------------
    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = 8'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_windows(input int n);
        int target;
        int budget;
        target = windows_done + n;
        budget = (n + 1) * P;
        while (windows_done < target && budget > 0) begin
            step();
            budget--;
        end
        check("window_wait", windows_done, target);
    endtask

    task automatic wait_phase(input int ph);
        int budget;
        budget = 2 * P;
        while ((c % P) != ph && budget > 0) begin
            step();
            budget--;
        end
        check("phase_wait", c % P, ph);
    endtask

    typedef struct {
        int addr;
        int data;
        int ch;
        int exp_hi;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;

        vecs[0] = '{addr: 0,  data: 100, ch: 0,  exp_hi: 100 * DIV};
        vecs[1] = '{addr: 1,  data: 0,   ch: 1,  exp_hi: 0};
        vecs[2] = '{addr: 17, data: 200, ch: 17, exp_hi: P};
        vecs[3] = '{addr: 3,  data: 255, ch: 3,  exp_hi: P};
        vecs[4] = '{addr: 4,  data: 201, ch: 4,  exp_hi: P};
        vecs[5] = '{addr: 20, data: 100, ch: 0,  exp_hi: 100 * DIV};

        // Reset state
        repeat (3) step();
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_period_start", int'(period_start), 0);
        RESET = 1'b0;

        // Table-driven duty writes, each observed over one full period
        foreach (vecs[k]) begin
            do_write(vecs[k].addr, vecs[k].data);
            wait_windows(2);
            check($sformatf("table row %0d addr=%0d", k, vecs[k].addr),
                  last_hi[vecs[k].ch], vecs[k].exp_hi);
        end

        // Mid-period write: no effect until the next period
        wait_phase(P / 2);
        do_write(5, 50);
        wait_windows(1);
        check("midperiod ch5 old duty", last_hi[5], 0);
        wait_windows(1);
        check("midperiod ch5 new duty", last_hi[5], 50 * DIV);

        // Write on the exact wrap edge is included in the load
        wait_phase(P - 1);
        do_write(6, 80);
        check("wrap_edge ch6 previous period", last_hi[6], 0);
        wait_windows(1);
        check("wrap_edge ch6 first period", last_hi[6], 80 * DIV);

        // One-cycle reset mid-period with a simultaneous write
        wait_phase(P / 2 + 123);
        RESET   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 8'd150;
        step();
        RESET = 1'b0;
        wr_en = 1'b0;
        check("reset_mid pwm_out", int'(pwm_out), 0);
        check("reset_mid period_start", int'(period_start), 0);
        n = 0;
        while (period_start !== 1'b1 && n < 2 * P) begin
            step();
            n++;
        end
        check("cycles release->period_start", n, P);
        wait_windows(1);
        check("reset write lost ch7", last_hi[7], 0);
        check("reset cleared ch0", last_hi[0], 0);

        // Randomized writes, checked every cycle by the model
        for (int k = 0; k < 6 * P; k++) begin
            if ($urandom_range(0, 19) == 0 || (c % P) == P - 1) begin
                wr_en   = 1'b1;
                wr_addr = 5'($urandom_range(0, 23));
                wr_data = 8'($urandom_range(0, 255));
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
        wait_windows(2);

        if (win_len > 0) check_mismatches();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
